// File: rtl/lsu_rmw_pkg.sv
// Shared types for the load/store unit: word type, access size, FSM state,
// latched request and the request error check.
package lsu_rmw_pkg;
   typedef logic [31:0] rvword_t;

   typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} memsize_e;

   typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_READ} lsu_state_e;

   typedef struct packed {
      logic [1:0] size;
      logic       uns;
      logic [1:0] ofs;
      rvword_t    wdata;
   } lsu_req_t;

   // Misaligned, beyond the memory, or size code 3.
   function automatic logic req_error(input logic [1:0] size, input rvword_t addr,
                                      input int unsigned mem_width);
      logic mis, oor;
      mis = (size == SZ_H && addr[0]) || (size == SZ_W && addr[1:0] != 2'b00);
      oor = (addr >> (mem_width + 2)) != '0;
      return mis || oor || (size == 2'd3);
   endfunction
endpackage

// File: rtl/lsu_rmw_if.sv
// Core request/response handshake plus the single-ported memory data port.
interface lsu_rmw_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        dwe;
   logic [31:0] daddr;
   logic [31:0] ddatain;
   logic [31:0] ddataout;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ddataout,
      output req_ready, resp_valid, resp_rdata, resp_err, dwe, daddr, ddatain
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ddataout,
      input  req_ready, resp_valid, resp_rdata, resp_err, dwe, daddr, ddatain
   );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: load extract with sign/zero extension, and sub-word
// store merge into the old memory word.
module lsu_lane_align
   import lsu_rmw_pkg::*;
(
   input  rvword_t    rword,
   input  logic [1:0] ofs,
   input  logic [1:0] size,
   input  logic       uns,
   output rvword_t    rdata,
   input  rvword_t    old,
   input  rvword_t    wdata,
   output rvword_t    merged
);
   localparam int NUM_LANES = 4;

   rvword_t              shifted;
   rvword_t              wrep;
   logic [NUM_LANES-1:0] be;

   always_comb begin
      shifted = rword >> {ofs, 3'b000};
      case (size)
         SZ_B:    rdata = {{24{~uns & shifted[7]}}, shifted[7:0]};
         SZ_H:    rdata = {{16{~uns & shifted[15]}}, shifted[15:0]};
         default: rdata = rword;
      endcase
   end

   // Replicate store data across lanes so each lane just picks old or new.
   always_comb begin
      case (size)
         SZ_B:    wrep = {4{wdata[7:0]}};
         SZ_H:    wrep = {2{wdata[15:0]}};
         default: wrep = wdata;
      endcase
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      localparam logic [1:0] LN = 2'(i);
      assign be[i] = (size == SZ_B) ? (ofs == LN) :
                     (size == SZ_H) ? (ofs[1] == LN[1]) : 1'b1;
      assign merged[8*i +: 8] = be[i] ? wrep[8*i +: 8] : old[8*i +: 8];
   end
endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit FSM: word stores write on accept, loads wait one cycle for
// memory data, sub-word stores read then write the merged word.
module lsu_rmw
   import lsu_rmw_pkg::*;
#(
   parameter int MEM_WIDTH = 16
) (
   input logic       clk,
   input logic       rst,
   lsu_rmw_if.slave  bus
);
   lsu_state_e           state;
   lsu_req_t             lat;
   logic [MEM_WIDTH-1:0] lat_idx;
   logic                 req_err;
   logic                 accept;
   rvword_t              ext;
   rvword_t              merged;
   logic                 dwe;
   rvword_t              daddr;
   rvword_t              ddatain;

   assign bus.req_ready = (state == IDLE);
   assign accept        = bus.req_valid && bus.req_ready;
   assign req_err       = req_error(bus.req_size, bus.req_addr, MEM_WIDTH);

   lsu_lane_align u_align (
      .rword  (bus.ddataout),
      .ofs    (lat.ofs),
      .size   (lat.size),
      .uns    (lat.uns),
      .rdata  (ext),
      .old    (bus.ddataout),
      .wdata  (lat.wdata),
      .merged (merged)
   );

   // In IDLE the port follows the live request so the access begins on the accept edge.
   always_comb begin
      dwe     = 1'b0;
      daddr   = {{(32-MEM_WIDTH){1'b0}}, lat_idx};
      ddatain = merged;
      if (state == IDLE) begin
         daddr   = {{(32-MEM_WIDTH){1'b0}}, bus.req_addr[MEM_WIDTH+1:2]};
         ddatain = bus.req_wdata;
         dwe     = bus.req_valid && bus.req_we && (bus.req_size == SZ_W) && !req_err && !rst;
      end else if (state == RMW_READ) begin
         dwe = !rst;
      end
   end

   assign bus.dwe     = dwe;
   assign bus.daddr   = daddr;
   assign bus.ddatain = ddatain;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         bus.resp_valid <= 1'b0;
         bus.resp_rdata <= '0;
         bus.resp_err   <= 1'b0;
         lat            <= '0;
         lat_idx        <= '0;
      end else begin
         bus.resp_valid <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               lat     <= '{size: bus.req_size, uns: bus.req_unsigned,
                            ofs: bus.req_addr[1:0], wdata: bus.req_wdata};
               lat_idx <= bus.req_addr[MEM_WIDTH+1:2];
               if (req_err) begin
                  bus.resp_valid <= 1'b1;
                  bus.resp_err   <= 1'b1;
                  bus.resp_rdata <= '0;
               end else if (!bus.req_we) begin
                  state <= LOAD_WAIT;
               end else if (bus.req_size == SZ_W) begin
                  bus.resp_valid <= 1'b1;
                  bus.resp_err   <= 1'b0;
                  bus.resp_rdata <= '0;
               end else begin
                  state <= RMW_READ;
               end
            end
            LOAD_WAIT: begin
               bus.resp_valid <= 1'b1;
               bus.resp_err   <= 1'b0;
               bus.resp_rdata <= ext;
               state          <= IDLE;
            end
            RMW_READ: begin
               bus.resp_valid <= 1'b1;
               bus.resp_err   <= 1'b0;
               bus.resp_rdata <= '0;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_rmw.sv
// Directed and randomized checks of lsu_rmw against a behavioural memory
// and a byte-array reference.
module tb_lsu_rmw;
   localparam int MW = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lsu_rmw_if bus();

   lsu_rmw #(.MEM_WIDTH(MW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [31:0]   mem [0:(1<<MW)-1];
   logic          pre_we = 1'b0;
   logic [MW-1:0] pre_addr = '0;
   logic [31:0]   pre_data = '0;
   int            dwe_cnt = 0;
   logic [31:0]   wr_addr = '0;
   logic [31:0]   wr_data = '0;

   // Single-port memory, one-cycle read latency; pre_* lets the bench preload words.
   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (bus.dwe) begin
         mem[bus.daddr[MW-1:0]] <= bus.ddatain;
         dwe_cnt <= dwe_cnt + 1;
         wr_addr <= bus.daddr;
         wr_data <= bus.ddatain;
      end
      bus.ddataout <= mem[bus.daddr[MW-1:0]];
   end

   int checks = 0;
   int fails  = 0;
   logic [7:0] refm [0:255];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic poke(input int unsigned a, input logic [31:0] d);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = a[MW-1:0]; pre_data = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   // Issue one request and wait for its response; returns at the negedge of the response cycle.
   task automatic do_req(input string tag, input bit now, input bit we, input logic [1:0] size,
                         input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input int lat, input logic [31:0] exp_rd, input bit exp_err,
                         input bit exp_dwe);
      int cyc;
      if (!now) @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
      bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
      #1;
      check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
      check({tag, " dwe"}, 32'(bus.dwe), 32'(exp_dwe));
      if (!exp_err) check({tag, " daddr"}, bus.daddr, addr >> 2);
      @(negedge clk);
      cyc = 1;
      bus.req_valid = 1'b0;
      while (!bus.resp_valid && cyc < 5) begin
         check({tag, " busy"}, 32'(bus.req_ready), 32'd0);
         @(negedge clk);
         cyc++;
      end
      check({tag, " latency"}, 32'(cyc), 32'(lat));
      check({tag, " rdata"}, bus.resp_rdata, exp_rd);
      check({tag, " err"}, 32'(bus.resp_err), 32'(exp_err));
   endtask

   initial begin
      int d0;
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
      bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h1234_5678;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst dwe", 32'(bus.dwe), 32'd0);
      check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst rdata", bus.resp_rdata, 32'd0);
      check("rst err", 32'(bus.resp_err), 32'd0);
      check("rst ready", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Loads with extension
      poke(32'h10, 32'h8899_AABB);
      do_req("lb 0x41", 0, 0, 2'd0, 0, 32'h41, 32'h0, 2, 32'hFFFF_FFAA, 0, 0);
      do_req("lhu 0x42", 0, 0, 2'd1, 1, 32'h42, 32'h0, 2, 32'h0000_8899, 0, 0);
      do_req("lbu 0x40", 0, 0, 2'd0, 1, 32'h40, 32'h0, 2, 32'h0000_00BB, 0, 0);
      do_req("lh 0x40", 0, 0, 2'd1, 0, 32'h40, 32'h0, 2, 32'hFFFF_AABB, 0, 0);

      // Sub-word store read-modify-write
      d0 = dwe_cnt;
      do_req("sb 0x43", 0, 1, 2'd0, 0, 32'h43, 32'h0000_005C, 2, 32'h0, 0, 0);
      check("sb dwe count", 32'(dwe_cnt - d0), 32'd1);
      check("sb wr data", wr_data, 32'h5C99_AABB);
      check("sb wr addr", wr_addr, 32'h10);
      do_req("lw 0x40", 0, 0, 2'd2, 0, 32'h40, 32'h0, 2, 32'h5C99_AABB, 0, 0);
      do_req("sh 0x40", 0, 1, 2'd1, 0, 32'h40, 32'hFFFF_1234, 2, 32'h0, 0, 0);
      do_req("lw 0x40 b", 0, 0, 2'd2, 0, 32'h40, 32'h0, 2, 32'h5C99_1234, 0, 0);

      // Word store then back-to-back load
      do_req("sw 0x80", 0, 1, 2'd2, 0, 32'h80, 32'hDEAD_BEEF, 1, 32'h0, 0, 1);
      do_req("lw 0x80 b2b", 1, 0, 2'd2, 0, 32'h80, 32'h0, 2, 32'hDEAD_BEEF, 0, 0);

      // Errors never touch memory
      d0 = dwe_cnt;
      do_req("lh misaligned", 0, 0, 2'd1, 0, 32'h101, 32'h0, 1, 32'h0, 1, 0);
      do_req("sw out of range", 0, 1, 2'd2, 0, 32'(1) << (MW + 2), 32'h5555_5555, 1, 32'h0, 1, 0);
      do_req("sw misaligned", 0, 1, 2'd2, 0, 32'h82, 32'h5555_5555, 1, 32'h0, 1, 0);
      do_req("size 3", 0, 0, 2'd3, 0, 32'h40, 32'h0, 1, 32'h0, 1, 0);
      check("err dwe count", 32'(dwe_cnt - d0), 32'd0);

      // Reset during RMW_READ abandons the write
      poke(32'h11, 32'h1122_3344);
      d0 = dwe_cnt;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
      bus.req_addr = 32'h44; bus.req_wdata = 32'hEE;
      @(negedge clk);
      bus.req_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("rmw rst dwe", 32'(bus.dwe), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rmw rst ready", 32'(bus.req_ready), 32'd1);
      check("rmw rst resp", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
      check("rmw rst resp 2", 32'(bus.resp_valid), 32'd0);
      check("rmw rst mem", mem[16'h11], 32'h1122_3344);
      check("rmw rst dwe count", 32'(dwe_cnt - d0), 32'd0);

      // Random mixed traffic over 64 words against a byte model
      for (int w = 0; w < 64; w++) begin
         logic [31:0] v;
         v = $urandom;
         poke(w, v);
         for (int k = 0; k < 4; k++) refm[w*4+k] = v[8*k +: 8];
      end
      @(negedge clk);
      for (int n = 0; n < 1000; n++) begin
         logic [1:0]  sz;
         logic [7:0]  a;
         logic [31:0] wd, exp;
         bit          we, uns;
         int          gap;
         sz  = 2'($urandom_range(0, 2));
         a   = 8'($urandom_range(0, 255));
         if (sz == 2'd1) a[0] = 1'b0;
         if (sz == 2'd2) a[1:0] = 2'b00;
         we  = 1'($urandom_range(0, 1));
         uns = 1'($urandom_range(0, 1));
         wd  = $urandom;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check("rnd idle resp", 32'(bus.resp_valid), 32'd0);
         end
         exp = '0;
         if (we) begin
            refm[a] = wd[7:0];
            if (sz != 2'd0) refm[a+1] = wd[15:8];
            if (sz == 2'd2) begin refm[a+2] = wd[23:16]; refm[a+3] = wd[31:24]; end
            do_req("rnd st", 1, 1, sz, uns, {24'h0, a}, wd, (sz == 2'd2) ? 1 : 2, 32'h0, 0, sz == 2'd2);
         end else begin
            case (sz)
               2'd0:    exp = uns ? {24'h0, refm[a]} : {{24{refm[a][7]}}, refm[a]};
               2'd1:    exp = uns ? {16'h0, refm[a+1], refm[a]}
                                  : {{16{refm[a+1][7]}}, refm[a+1], refm[a]};
               default: exp = {refm[a+3], refm[a+2], refm[a+1], refm[a]};
            endcase
            do_req("rnd ld", 1, 0, sz, uns, {24'h0, a}, wd, 2, exp, 0, 0);
         end
      end
      @(negedge clk);
      for (int w = 0; w < 64; w++)
         check("rnd mem", mem[w], {refm[w*4+3], refm[w*4+2], refm[w*4+1], refm[w*4]});

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
Load/store unit between the core's execute stage and the data port of the single-ported word memory.
- Accepts byte-addressed loads and stores of byte, half or word size.
- Converts them to word-indexed memory accesses.
- Performs sign/zero extension on loads.
- Implements sub-word stores as read-modify-write, because the memory has only a whole-word write enable.
- Flags misaligned and out-of-range accesses without touching memory.

Parameters:
MEM_WIDTH, 16, log2 of memory depth in 32-bit words; must match the memory instance.

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
req_valid  input  1  core request present
req_ready  output  1  unit can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal
req_unsigned  input  1  loads: zero-extend when 1, sign-extend when 0
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  single-cycle completion pulse; no back-pressure
resp_rdata  output  32  load result; 0 for stores and errors
resp_err  output  1  misaligned, out-of-range or illegal-size request
dwe  output  1  memory write enable
daddr  output  32  memory word index, byte address >> 2
ddatain  output  32  memory write data
ddataout  input  32  memory read data; valid the cycle after daddr is sampled

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state IDLE, resp_valid=0, resp_rdata=0, resp_err=0. While rst=1, dwe=0.
- Reset mid-operation abandons the access. A pending RMW write is never issued and no response is produced.
- Accept: req_valid && req_ready at a rising edge. req_ready=1 only in IDLE (combinational from state). Request fields are latched on accept.
- Error check at accept:
  - misaligned: half with addr[0]=1, or word with addr[1:0]!=0;
  - out of range: addr[31:MEM_WIDTH+2] != 0;
  - illegal size: req_size=3.
  - On error: no memory access, dwe=0. Next cycle resp_valid=1, resp_err=1, resp_rdata=0, state IDLE.
- Memory drive in IDLE is combinational from the request, so the access starts on the accept edge:
  - daddr = {0, req_addr[MEM_WIDTH+1:2]}.
  - dwe = req_valid && req_we && size==word && no error.
  - ddatain = req_wdata.
  - All other states drive daddr from the latched address.
- States:
  - IDLE
    - load → LOAD_WAIT.
    - word store → writes on the accept edge; resp_valid next cycle; back to IDLE.
    - sub-word store → RMW_READ.
  - LOAD_WAIT: select lane from ddataout using latched addr[1:0] and size, then extend. Register resp_rdata and set resp_valid=1 next cycle. → IDLE.
  - RMW_READ:
    - merge = ddataout with the byte at lane addr[1:0], or the half at lane addr[1], replaced by the low bits of latched wdata;
    - drive dwe=1, ddatain=merge;
    - resp_valid next cycle; → IDLE.
- Latency (accept at cycle N):
  - load: resp in N+2;
  - word store: resp in N+1;
  - sub-word store: read at edge N, write at edge N+1, resp in N+2;
  - error: resp in N+1.
- Throughput: req_ready is high in the same cycle resp_valid is high, so back-to-back issue is allowed.
- The RMW sequence is atomic: no other data-port access is interleaved. A load accepted after a store completes returns the new value.
- Addresses wrap within the memory only through index truncation; out-of-range addresses are errored, never aliased.

Decomposition:
- Shared types header alongside rvwordT: memsize enum (SZ_B=0, SZ_H=1, SZ_W=2).
- lsu_rmw_pkg: lsu_state enum and the error-check function.
- One combinational sub-module, lsu_lane_align:
  - load extract/extend: ddataout, addr[1:0], size, unsigned → rdata;
  - store merge: old word, wdata, addr[1:0], size → merged word.
  - Tested standalone; lsu_rmw holds the FSM and registers.

Test Plan:
1. Memory word 0x10 = 0x8899AABB; load byte signed at addr 0x41 → resp_valid at N+2, rdata=0xFFFFFFAA, err=0. Load half unsigned at addr 0x42 → rdata=0x00008899.
2. Store byte 0x5C at addr 0x43 on word 0x8899AABB → one read at N, one dwe pulse at N+1 with ddatain=0x5C99AABB, resp at N+2. Subsequent word load returns 0x5C99AABB.
3. Store word 0xDEADBEEF at addr 0x80 → dwe=1 in accept cycle, daddr=0x20, resp_valid at N+1. Back-to-back load of 0x80 accepted that cycle returns 0xDEADBEEF.
4. Errors, none touch memory (dwe never asserted): half load at addr 0x101 → resp_err=1 at N+1. Word store at addr 1<<(MEM_WIDTH+2) → resp_err=1. req_size=3 → resp_err=1.
5. Assert rst during RMW_READ of a byte store → dwe stays 0, no resp_valid, memory word unchanged, req_ready=1 the cycle after rst deasserts.
6. Random sequence of 1000 mixed-size loads/stores with random stall gaps, checked against a byte-array reference model: all data matches, no req_ready while busy, exactly one resp_valid per accept.
